if_fetch_queue: RTL and testbench

Parametrised instruction-fetch front end for the pipelined CPU. It replaces the bare PC register, the PC+4 adder and the next-PC muxing. It owns the fetch PC, drives the instruction-memory address, and buffers fetched instructions with their PCs in a DEPTH-entry queue. The queue feeds the IF/ID stage, so a decode stall no longer freezes fetch, and a branch/jump redirect flushes all wrong-path entries in one cycle.

---
 rtl/if_fetch_queue.sv | 98 +++++++++
 tb/tb_if_fetch_queue.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC and buffers fetched words with
// their PCs in a DEPTH-entry queue. A redirect flushes the queue and refetches in one cycle.
module if_fetch_queue #(
  parameter int               XLEN     = 32,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       start_i,
  output logic [XLEN-1:0]            imem_addr_o,
  input  logic [31:0]                imem_data_i,
  input  logic                       redirect_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  input  logic                       stall_i,
  output logic                       inst_valid_o,
  output logic [31:0]                inst_o,
  output logic [XLEN-1:0]            pc_o,
  output logic [XLEN-1:0]            pc_plus4_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [XLEN-1:0]  PC_ALIGN = {{(XLEN-2){1'b1}}, 2'b00};

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
  } entry_t;

  entry_t            storage_q [DEPTH];
  entry_t            storage_d [DEPTH];
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty, deq, enq;
  entry_t            head;

  always_comb begin
    empty      = (count_q == '0);
    deq        = ~empty & ~stall_i & ~redirect_i;
    // A full queue still accepts a word when the head leaves in the same cycle.
    enq        = start_i & ~redirect_i & ((count_q != FULL_CNT) | deq);
    storage_d  = storage_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    if (redirect_i) begin
      count_d    = '0;
      rd_ptr_d   = wr_ptr_q;
      fetch_pc_d = redirect_pc_i & PC_ALIGN;
    end else begin
      if (enq) begin
        storage_d[wr_ptr_q] = '{pc: fetch_pc_q, inst: imem_data_i};
        wr_ptr_d            = wr_ptr_q + PTR_W'(1);
        fetch_pc_d          = fetch_pc_q + XLEN'(4);
      end
      if (deq) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      fetch_pc_q <= RESET_PC & PC_ALIGN;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage is never reset; entries are only visible through count_q.
  always_ff @(posedge clk_i) begin
    storage_q <= storage_d;
  end

  always_comb begin
    head         = storage_q[rd_ptr_q];
    imem_addr_o  = fetch_pc_q;
    count_o      = count_q;
    inst_valid_o = ~empty;
    inst_o       = empty ? 32'd0 : head.inst;
    pc_o         = empty ? '0 : head.pc;
    pc_plus4_o   = empty ? '0 : head.pc + XLEN'(4);
  end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: directed scenarios plus random traffic against a
// queue-based reference model (XLEN=32), and a PC-wrap scenario on an XLEN=8 instance.
module tb_if_fetch_queue;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // 32-bit instance
  logic        rst, start, redirect, stall, valid;
  logic [31:0] redirect_pc, addr, data, inst, pc, pc4, mem_key;
  logic [2:0]  cnt;
  assign data = addr ^ mem_key;

  if_fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h100)) dut_a (
    .clk_i(clk), .rst_i(rst), .start_i(start), .imem_addr_o(addr), .imem_data_i(data),
    .redirect_i(redirect), .redirect_pc_i(redirect_pc), .stall_i(stall),
    .inst_valid_o(valid), .inst_o(inst), .pc_o(pc), .pc_plus4_o(pc4), .count_o(cnt)
  );

  // 8-bit instance for address wrap
  logic        b_rst, b_start, b_redirect, b_stall, b_valid;
  logic [7:0]  b_redirect_pc, b_addr, b_pc, b_pc4;
  logic [31:0] b_data, b_inst;
  logic [2:0]  b_cnt;
  assign b_data = {24'h0, b_addr};

  if_fetch_queue #(.XLEN(8), .DEPTH(4), .RESET_PC(8'hF0)) dut_b (
    .clk_i(clk), .rst_i(b_rst), .start_i(b_start), .imem_addr_o(b_addr), .imem_data_i(b_data),
    .redirect_i(b_redirect), .redirect_pc_i(b_redirect_pc), .stall_i(b_stall),
    .inst_valid_o(b_valid), .inst_o(b_inst), .pc_o(b_pc), .pc_plus4_o(b_pc4), .count_o(b_cnt)
  );

  // Reference model: queue of {pc, inst} plus the fetch PC.
  logic [63:0] mq[$];
  logic [31:0] m_fpc;

  task automatic model_edge();
    bit do_deq, do_enq;
    if (!rst) begin
      mq.delete();
      m_fpc = 32'h100;
    end else if (redirect) begin
      mq.delete();
      m_fpc = {redirect_pc[31:2], 2'b00};
    end else begin
      do_deq = (mq.size() != 0) && !stall;
      do_enq = start && ((mq.size() < 4) || do_deq);
      if (do_deq) void'(mq.pop_front());
      if (do_enq) begin
        mq.push_back({m_fpc, m_fpc ^ mem_key});
        m_fpc = m_fpc + 32'd4;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_a();
    logic [31:0] epc, einst, epc4;
    if (mq.size() != 0) begin
      epc   = mq[0][63:32];
      einst = mq[0][31:0];
      epc4  = epc + 32'd4;
    end else begin
      epc = '0; einst = '0; epc4 = '0;
    end
    chk("a_addr",  64'(addr),  64'(m_fpc));
    chk("a_count", 64'(cnt),   64'(mq.size()));
    chk("a_valid", 64'(valid), 64'(mq.size() != 0));
    chk("a_inst",  64'(inst),  64'(einst));
    chk("a_pc",    64'(pc),    64'(epc));
    chk("a_pc4",   64'(pc4),   64'(epc4));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    check_a();
  endtask

  initial begin
    int exp_c[6];
    logic [7:0] epc;
    exp_c = '{1, 2, 3, 4, 4, 4};
    rst = 0; start = 0; redirect = 0; stall = 0; redirect_pc = '0; mem_key = '0;
    b_rst = 0; b_start = 0; b_redirect = 0; b_stall = 0; b_redirect_pc = '0;

    // Reset state
    step(); step();
    chk("rst_addr", 64'(addr), 64'h100);
    chk("rst_valid", 64'(valid), 64'h0);

    // Streaming with word = address
    rst = 1; start = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk("stream_pc", 64'(pc), 64'(32'h100 + 32'(4 * k)));
      chk("stream_cnt", 64'(cnt), 64'd1);
    end

    // Fill under stall
    rst = 0; step(); rst = 1; stall = 1;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("fill_cnt", 64'(cnt), 64'(exp_c[k]));
      chk("fill_head", 64'(pc), 64'h100);
    end
    chk("fill_addr", 64'(addr), 64'h110);

    // Full with simultaneous enq/deq
    stall = 0; step();
    chk("full_cnt", 64'(cnt), 64'd4);
    chk("full_head", 64'(pc), 64'h104);
    chk("full_addr", 64'(addr), 64'h114);
    stall = 1; step();
    stall = 0; repeat (3) step();

    // Redirect while full, with a same-cycle stall
    redirect = 1; redirect_pc = 32'h203; stall = 1; step();
    chk("redir_cnt", 64'(cnt), 64'd0);
    chk("redir_valid", 64'(valid), 64'd0);
    chk("redir_addr", 64'(addr), 64'h200);
    redirect = 0; stall = 0; step();
    chk("redir_head", 64'(pc), 64'h200);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 99) >= 3);
      start       = ($urandom_range(0, 99) < 80);
      stall       = ($urandom_range(0, 99) < 40);
      redirect    = ($urandom_range(0, 99) < 8);
      redirect_pc = $urandom;
      if ($urandom_range(0, 15) == 0) mem_key = $urandom;
      step();
    end

    // start_i low: queue drains, fetch PC frozen
    rst = 1; redirect = 0; start = 0; stall = 0;
    repeat (6) step();
    chk("drain_inst", 64'(inst), 64'h0);
    chk("drain_valid", 64'(valid), 64'h0);

    // Reset while full
    start = 1; stall = 1; repeat (5) step();
    chk("prerst_cnt", 64'(cnt), 64'd4);
    rst = 0; step();
    chk("midrst_addr", 64'(addr), 64'h100);
    chk("midrst_valid", 64'(valid), 64'h0);
    chk("midrst_inst", 64'(inst), 64'h0);
    chk("midrst_pc", 64'(pc), 64'h0);
    chk("midrst_pc4", 64'(pc4), 64'h0);
    chk("midrst_cnt", 64'(cnt), 64'h0);
    rst = 1; stall = 0; step();
    chk("resume_pc", 64'(pc), 64'h100);
    start = 0;

    // 8-bit instance: PC wrap and pointer wrap
    step();
    chk("b_rst_addr", 64'(b_addr), 64'hF0);
    chk("b_rst_cnt", 64'(b_cnt), 64'h0);
    b_rst = 1; b_start = 1;
    for (int k = 1; k <= 10; k++) begin
      step();
      epc = 8'hF0 + 8'(4 * (k - 1));
      chk("b_pc", 64'(b_pc), 64'(epc));
      chk("b_inst", 64'(b_inst), 64'(epc));
      chk("b_pc4", 64'(b_pc4), 64'(8'(epc + 8'd4)));
      chk("b_addr", 64'(b_addr), 64'(8'(epc + 8'd4)));
      chk("b_cnt", 64'(b_cnt), 64'd1);
    end
    b_stall = 1;
    for (int j = 1; j <= 3; j++) begin
      step();
      chk("b_fill_cnt", 64'(b_cnt), 64'(1 + j));
      chk("b_fill_head", 64'(b_pc), 64'h14);
      chk("b_fill_addr", 64'(b_addr), 64'(8'h18 + 8'(4 * j)));
    end
    b_stall = 0; b_start = 0;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("b_drain_cnt", 64'(b_cnt), 64'(4 - j));
      chk("b_drain_addr", 64'(b_addr), 64'h24);
      if (j < 4) begin
        chk("b_drain_pc", 64'(b_pc), 64'(8'h14 + 8'(4 * j)));
        chk("b_drain_inst", 64'(b_inst), 64'(8'h14 + 8'(4 * j)));
      end else begin
        chk("b_empty_inst", 64'(b_inst), 64'h0);
        chk("b_empty_pc", 64'(b_pc), 64'h0);
        chk("b_empty_pc4", 64'(b_pc4), 64'h0);
        chk("b_empty_valid", 64'(b_valid), 64'h0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
